// File: rtl/defuzz_nt.sv
// Nie-Tan type reduction and centroid defuzzifier for the IT2 fuzzy controller output stage.
// It accumulates one rule per cycle and then runs a serial restoring divide that yields one quotient bit per cycle.
module defuzz_nt #(
    parameter int                              N_REGRAS   = 9,
    parameter int                              LARGURA    = 8,
    parameter logic [N_REGRAS*LARGURA-1:0]     CENTROIDES = {8'd255, 8'd224, 8'd192, 8'd160,
                                                             8'd128, 8'd96, 8'd64, 8'd32, 8'd0}
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            EN_Entrada_Defuzz,
    input  logic [N_REGRAS*LARGURA-1:0]     Forca_UP,
    input  logic [N_REGRAS*LARGURA-1:0]     Forca_LOW,
    output logic [LARGURA-1:0]              Saida,
    output logic                            Pronto,
    output logic                            Vazio,
    output logic                            Ocupado
);
    localparam int IW = $clog2(N_REGRAS);
    localparam int SW = LARGURA + 1;
    localparam int PW = SW + LARGURA;
    localparam int NW = PW + IW;
    localparam int DW = SW + IW;
    localparam int CW = $clog2(LARGURA);

    typedef logic [N_REGRAS-1:0][LARGURA-1:0] vec_t;
    localparam vec_t CENT = CENTROIDES;

    typedef enum logic [1:0] {OCIOSO, ACUMULA, DIVIDE, FIM} estado_t;

    estado_t         estado, prox;
    vec_t            up_r, low_r;
    logic [IW-1:0]   idx;
    logic [NW-1:0]   num, rem, dvs;
    logic [DW-1:0]   den;
    logic [CW-1:0]   cnt;
    logic [LARGURA-1:0] quo;

    logic [SW-1:0]   soma;
    logic [PW-1:0]   prod;
    logic [NW-1:0]   num_nxt;
    logic [DW-1:0]   den_nxt;
    logic            ult_regra, ult_bit, q_bit;
    logic [LARGURA-1:0] quo_nxt;

    always_comb begin
        soma      = SW'(up_r[idx]) + SW'(low_r[idx]);
        prod      = PW'(soma) * PW'(CENT[idx]);
        num_nxt   = num + NW'(prod);
        den_nxt   = den + DW'(soma);
        ult_regra = (idx == IW'(N_REGRAS - 1));
        ult_bit   = (cnt == CW'(LARGURA - 1));
        q_bit     = (rem >= dvs);
        quo_nxt   = {quo[LARGURA-2:0], q_bit};
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:  if (EN_Entrada_Defuzz) prox = ACUMULA;
            ACUMULA: if (ult_regra)         prox = DIVIDE;
            DIVIDE:  if (ult_bit)           prox = FIM;
            FIM:                            prox = OCIOSO;
            default:                        prox = OCIOSO;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) estado <= OCIOSO;
        else       estado <= prox;
    end

    assign Ocupado = (estado != OCIOSO);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            up_r   <= '0;
            low_r  <= '0;
            idx    <= '0;
            num    <= '0;
            den    <= '0;
            rem    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            quo    <= '0;
            Saida  <= '0;
            Pronto <= 1'b0;
            Vazio  <= 1'b0;
        end else begin
            Pronto <= 1'b0;
            case (estado)
                OCIOSO: if (EN_Entrada_Defuzz) begin
                    up_r  <= Forca_UP;
                    low_r <= Forca_LOW;
                    num   <= '0;
                    den   <= '0;
                    idx   <= '0;
                end
                ACUMULA: begin
                    num <= num_nxt;
                    den <= den_nxt;
                    idx <= idx + 1'b1;
                    // The quotient fits in LARGURA bits, so the divisor starts aligned to the quotient MSB.
                    if (ult_regra) begin
                        rem <= num_nxt;
                        dvs <= NW'(den_nxt) << (LARGURA - 1);
                        cnt <= '0;
                        quo <= '0;
                    end
                end
                DIVIDE: begin
                    if (q_bit) rem <= rem - dvs;
                    dvs <= dvs >> 1;
                    quo <= quo_nxt;
                    cnt <= cnt + 1'b1;
                    if (ult_bit) begin
                        Pronto <= 1'b1;
                        if (den == '0) begin
                            Saida <= '0;
                            Vazio <= 1'b1;
                        end else begin
                            Saida <= quo_nxt;
                            Vazio <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_defuzz_nt.sv
// Directed and random checks of defuzz_nt against a weighted-average reference.
module tb_defuzz_nt;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        EN_Entrada_Defuzz;
    logic [71:0] Forca_UP, Forca_LOW;
    logic [7:0]  Saida;
    logic        Pronto, Vazio, Ocupado;

    int n_asrt = 0;
    int n_fail = 0;

    defuzz_nt dut (
        .CLK(CLK), .RESET(RESET), .EN_Entrada_Defuzz(EN_Entrada_Defuzz),
        .Forca_UP(Forca_UP), .Forca_LOW(Forca_LOW),
        .Saida(Saida), .Pronto(Pronto), .Vazio(Vazio), .Ocupado(Ocupado)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Crisp output = strength-weighted mean of the rule centroids.
    function automatic void model(input logic [71:0] up, input logic [71:0] low,
                                  output logic [7:0] q, output logic v);
        int num = 0, den = 0, c, s;
        for (int i = 0; i < 9; i++) begin
            c = (i == 8) ? 255 : 32 * i;
            s = int'(up[8*i +: 8]) + int'(low[8*i +: 8]);
            num += s * c;
            den += s;
        end
        v = (den == 0);
        q = (den == 0) ? 8'd0 : 8'(num / den);
    endfunction

    task automatic run(input string tag, input logic [71:0] up, input logic [71:0] low, input int poke);
        logic [7:0] eq;
        logic       ev;
        int         lat = 0;
        bit         seen = 0;
        model(up, low, eq, ev);
        @(negedge CLK);
        Forca_UP = up; Forca_LOW = low; EN_Entrada_Defuzz = 1'b1;
        @(negedge CLK);
        EN_Entrada_Defuzz = 1'b0;
        check({tag, "_busy"}, 32'(Ocupado), 1);
        for (int k = 1; k < 40 && !seen; k++) begin
            if (k == poke) begin
                Forca_UP  = 72'({$urandom(), $urandom(), $urandom()});
                Forca_LOW = 72'({$urandom(), $urandom(), $urandom()});
                EN_Entrada_Defuzz = 1'b1;
            end else begin
                EN_Entrada_Defuzz = 1'b0;
            end
            @(negedge CLK);
            lat = k;
            if (Pronto) seen = 1;
            else if (k < 17) check({tag, "_busy_run"}, 32'(Ocupado), 1);
        end
        EN_Entrada_Defuzz = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 1);
        if (seen) begin
            // Pronto is set by the 17th edge after the start edge.
            check({tag, "_latency"}, lat, 17);
            check({tag, "_saida"}, 32'(Saida), 32'(eq));
            check({tag, "_vazio"}, 32'(Vazio), 32'(ev));
            check({tag, "_busy_fim"}, 32'(Ocupado), 1);
            @(negedge CLK);
            check({tag, "_pronto_pulse"}, 32'(Pronto), 0);
            check({tag, "_idle"}, 32'(Ocupado), 0);
            check({tag, "_hold"}, 32'(Saida), 32'(eq));
        end
    endtask

    initial begin
        logic [71:0] z, r4u, r4l, tu, tl;
        int          cnt, last, npul;
        z = '0;
        r4u = '0; r4u[32 +: 8] = 8'd255;
        r4l = '0; r4l[32 +: 8] = 8'd100;

        RESET = 1'b1; EN_Entrada_Defuzz = 1'b0; Forca_UP = '0; Forca_LOW = '0;
        repeat (2) @(negedge CLK);
        check("rst_saida", 32'(Saida), 0);
        check("rst_pronto", 32'(Pronto), 0);
        check("rst_vazio", 32'(Vazio), 0);
        check("rst_ocupado", 32'(Ocupado), 0);
        RESET = 1'b0;

        run("zero", z, z, 0);
        check("zero_vazio_const", 32'(Vazio), 1);
        run("rule4", r4u, r4l, 0);
        check("rule4_const", 32'(Saida), 128);

        tu = '0; tu[7:0] = 8'd255; tu[64 +: 8] = 8'd255;
        run("trunc", tu, tu, 0);
        check("trunc_const", 32'(Saida), 127);

        // Inputs scrambled and an extra EN pulse during DIVIDE.
        tu = '0; tu[16 +: 8] = 8'd200; tu[48 +: 8] = 8'd100;
        run("latched", tu, z, 13);
        check("latched_const", 32'(Saida), 106);
        cnt = 0;
        repeat (25) begin @(negedge CLK); if (Pronto) cnt++; end
        check("no_extra_result", cnt, 0);

        // Abort with reset while idx=4.
        @(negedge CLK);
        Forca_UP = r4u; Forca_LOW = r4l; EN_Entrada_Defuzz = 1'b1;
        @(negedge CLK);
        EN_Entrada_Defuzz = 1'b0;
        repeat (4) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort_ocupado", 32'(Ocupado), 0);
        check("abort_saida", 32'(Saida), 0);
        check("abort_pronto", 32'(Pronto), 0);
        cnt = 0;
        repeat (25) begin @(negedge CLK); if (Pronto) cnt++; end
        check("abort_no_pronto", cnt, 0);
        run("after_abort", r4u, r4l, 0);

        for (int t = 0; t < 10; t++) begin
            tu = '0; tl = '0;
            for (int i = 0; i < 9; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    tu[8*i +: 8] = 8'($urandom_range(0, 255));
                    tl[8*i +: 8] = 8'($urandom_range(0, 255));
                end
            end
            if (t == 0) begin tu = '1; tl = '1; end
            run($sformatf("rand%0d", t), tu, tl, 0);
        end

        // EN held high: back-to-back results every 19 cycles.
        @(negedge CLK);
        Forca_UP = r4u; Forca_LOW = r4l; EN_Entrada_Defuzz = 1'b1;
        last = -1; npul = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (Pronto) begin
                if (last >= 0) check("held_spacing", k - last, 19);
                check("held_saida", 32'(Saida), 128);
                last = k;
                npul++;
            end
        end
        EN_Entrada_Defuzz = 1'b0;
        check("held_count", 32'(npul >= 3), 1);
        repeat (25) @(negedge CLK);
        check("held_idle", 32'(Ocupado), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
